// File: rtl/soc_defs_pkg.sv
// Shared core definitions: divider op/state encodings and stall bit index.
package soc_defs;

    localparam int unsigned STALL_EX = 2;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'd0,
        DIV_ST_CALC = 2'd1,
        DIV_ST_DONE = 2'd2
    } div_state_e;

    // DIV and REM are the signed variants (op[0] clear)
    function automatic logic div_op_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // REM and REMU return the remainder (op[1] set)
    function automatic logic div_op_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/ex_div_unit_step.sv
// One radix-2 restoring division iteration: shift {rem,quo} left, trial-subtract divisor.
module div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvsr_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0]   sh_c;
    logic [XLEN-1:0] diff_c;
    logic            borrow_c;

    // When no borrow, the difference is below the divisor, so XLEN bits hold it
    always_comb begin
        sh_c     = {rem_i, quo_i[XLEN-1]};
        borrow_c = sh_c < {1'b0, dvsr_i};
        diff_c   = sh_c[XLEN-1:0] - dvsr_i;
        rem_o    = borrow_c ? sh_c[XLEN-1:0] : diff_c;
        quo_o    = {quo_i[XLEN-2:0], ~borrow_c};
    end

endmodule

// File: rtl/ex_div_unit.sv
// Iterative RV32M divider for the EX stage; stalls EX while in flight, flush cancels.
// Optional result cache enabled by defining DIV_RESULT_CACHE_EN.
module ex_div_unit
    import soc_defs::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            stall_req,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            is_rem_q, is_rem_d, negq_q, negq_d, negr_q, negr_d;

    logic            signed_c, a_neg_c, b_neg_c, div0_c, ovf_c, accept_c, last_c;
    logic [XLEN-1:0] a_abs_c, b_abs_c, step_rem_c, step_quo_c, fin_quo_c, fin_rem_c;
    logic            cache_hit_c;
    logic [XLEN-1:0] cache_quo_c, cache_rem_c;

    // Operand decode, absolute values and special-case detection
    always_comb begin
        signed_c = div_op_signed(op);
        a_neg_c  = signed_c & dividend[XLEN-1];
        b_neg_c  = signed_c & divisor[XLEN-1];
        a_abs_c  = a_neg_c ? XLEN'(-dividend) : dividend;
        b_abs_c  = b_neg_c ? XLEN'(-divisor) : divisor;
        div0_c   = (divisor == '0);
        ovf_c    = signed_c & (dividend == MIN_VAL) & (divisor == '1);
        accept_c = (state_q == DIV_ST_IDLE) & start & ~flush;
        last_c   = (state_q == DIV_ST_CALC) & (count_q == CW'(1));
    end

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem_c),
        .quo_o  (step_quo_c)
    );

    // Sign fix applied to the final iteration's outputs
    always_comb begin
        fin_quo_c = negq_q ? XLEN'(-step_quo_c) : step_quo_c;
        fin_rem_c = negr_q ? XLEN'(-step_rem_c) : step_rem_c;
    end

`ifdef DIV_RESULT_CACHE_EN
    logic [XLEN-1:0] c_a_q, c_a_d, c_b_q, c_b_d, c_quo_q, c_quo_d, c_rem_q, c_rem_d;
    logic            c_sgn_q, c_sgn_d, c_vld_q, c_vld_d, from_calc_q, from_calc_d;

    // Cache lookup against the incoming operands
    always_comb begin
        cache_hit_c = c_vld_q & (c_a_q == dividend) & (c_b_q == divisor) & (c_sgn_q == signed_c);
        cache_quo_c = c_quo_q;
        cache_rem_c = c_rem_q;
    end

    // Entry is invalidated when a new computation starts and validated only on unflushed completion
    always_comb begin
        c_a_d       = c_a_q;
        c_b_d       = c_b_q;
        c_sgn_d     = c_sgn_q;
        c_quo_d     = c_quo_q;
        c_rem_d     = c_rem_q;
        c_vld_d     = c_vld_q;
        from_calc_d = from_calc_q;
        if (accept_c) begin
            from_calc_d = ~(div0_c | ovf_c | cache_hit_c);
            if (!(div0_c || ovf_c || cache_hit_c)) begin
                c_vld_d = 1'b0;
                c_a_d   = dividend;
                c_b_d   = divisor;
                c_sgn_d = signed_c;
            end
        end
        if (last_c && !flush) begin
            c_quo_d = fin_quo_c;
            c_rem_d = fin_rem_c;
        end
        if ((state_q == DIV_ST_DONE) && !flush && from_calc_q) begin
            c_vld_d = 1'b1;
        end
        if ((state_q == DIV_ST_CALC) && flush) begin
            c_vld_d = 1'b0;
        end
    end

    // Cache registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_a_q       <= '0;
            c_b_q       <= '0;
            c_sgn_q     <= 1'b0;
            c_quo_q     <= '0;
            c_rem_q     <= '0;
            c_vld_q     <= 1'b0;
            from_calc_q <= 1'b0;
        end else begin
            c_a_q       <= c_a_d;
            c_b_q       <= c_b_d;
            c_sgn_q     <= c_sgn_d;
            c_quo_q     <= c_quo_d;
            c_rem_q     <= c_rem_d;
            c_vld_q     <= c_vld_d;
            from_calc_q <= from_calc_d;
        end
    end
`else
    // No cache: never hits
    always_comb begin
        cache_hit_c = 1'b0;
        cache_quo_c = '0;
        cache_rem_c = '0;
    end
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= DIV_ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; flush wins over everything
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = DIV_ST_IDLE;
        end else begin
            unique case (state_q)
                DIV_ST_IDLE: if (start) state_d = (div0_c || ovf_c || cache_hit_c) ? DIV_ST_DONE : DIV_ST_CALC;
                DIV_ST_CALC: if (last_c) state_d = DIV_ST_DONE;
                DIV_ST_DONE: state_d = DIV_ST_IDLE;
                default:     state_d = DIV_ST_IDLE;
            endcase
        end
    end

    // FSM outputs; stall covers the issue cycle, flush and reset suppress stall and valid
    always_comb begin
        stall_req    = 1'b0;
        result_valid = 1'b0;
        busy         = (state_q != DIV_ST_IDLE);
        if (rst_n && !flush) begin
            stall_req    = ((state_q == DIV_ST_IDLE) & start) | (state_q == DIV_ST_CALC);
            result_valid = (state_q == DIV_ST_DONE);
        end
    end

    // Datapath next state: operand capture, iteration, result selection
    always_comb begin
        count_d  = count_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        is_rem_d = is_rem_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        if (accept_c) begin
            is_rem_d = div_op_rem(op);
            dvsr_d   = b_abs_c;
            rem_d    = '0;
            quo_d    = a_abs_c;
            count_d  = CW'(XLEN);
            negq_d   = a_neg_c ^ b_neg_c;
            negr_d   = a_neg_c;
            if (div0_c)           result_d = div_op_rem(op) ? dividend : '1;
            else if (ovf_c)       result_d = div_op_rem(op) ? '0 : MIN_VAL;
            else if (cache_hit_c) result_d = div_op_rem(op) ? cache_rem_c : cache_quo_c;
        end
        if ((state_q == DIV_ST_CALC) && !flush) begin
            rem_d   = step_rem_c;
            quo_d   = step_quo_c;
            count_d = count_q - CW'(1);
            if (last_c) result_d = is_rem_q ? fin_rem_c : fin_quo_c;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            is_rem_q <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            count_q  <= count_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            is_rem_q <= is_rem_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: results, latency, stall length, flush and async reset.
module tb_ex_div_unit;
    import soc_defs::*;

    localparam int unsigned XLEN = 32;
    localparam int LAT_FULL = XLEN + 2;
`ifdef DIV_RESULT_CACHE_EN
    localparam int LAT_HIT = 2;
`else
    localparam int LAT_HIT = LAT_FULL;
`endif

    logic            clk, rst_n, start, flush;
    logic [1:0]      op;
    logic [XLEN-1:0] dividend, divisor;
    logic            stall_req, busy, result_valid;
    logic [XLEN-1:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    ex_div_unit #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op           (op),
        .dividend     (dividend),
        .divisor      (divisor),
        .flush        (flush),
        .stall_req    (stall_req),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int          cyc;
        int          stalls;
        bit          got;
        logic [31:0] res;
        @(negedge clk);
        start = 1'b1; op = o; dividend = a; divisor = b;
        cyc = 0; stalls = 0; got = 1'b0; res = '0;
        for (int i = 0; i < LAT_FULL + 20 && !got; i++) begin
            #1;
            cyc++;
            if (stall_req) stalls++;
            if (result_valid) begin
                got = 1'b1;
                res = result;
            end else begin
                @(negedge clk);
            end
        end
        chk({tag, " valid"}, 32'(got), 32'd1);
        chk({tag, " result"}, res, exp);
        chk({tag, " latency"}, 32'(cyc), 32'(lat));
        chk({tag, " stall"}, 32'(stalls), 32'(lat - 1));
        if (got) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            chk({tag, " idle"}, 32'(busy), 32'd0);
        end else begin
            start = 1'b0;
        end
    endtask

    initial begin
        int rv_seen;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; dividend = '0; divisor = '0;
        #2;
        chk("reset stall", 32'(stall_req), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset valid", 32'(result_valid), 32'd0);
        chk("reset result", result, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back('{DIV_OP_DIVU, 32'd100,        32'd7,          32'd14,         LAT_FULL});
        vecs.push_back('{DIV_OP_REMU, 32'd100,        32'd7,          32'd2,          LAT_HIT});
        vecs.push_back('{DIV_OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  LAT_FULL});
        vecs.push_back('{DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  LAT_HIT});
        vecs.push_back('{DIV_OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  LAT_FULL});
        vecs.push_back('{DIV_OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          LAT_HIT});
        vecs.push_back('{DIV_OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  2});
        vecs.push_back('{DIV_OP_REM,  32'd5,          32'd0,          32'd5,          2});
        vecs.push_back('{DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2});
        vecs.push_back('{DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          2});
        vecs.push_back('{DIV_OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  2});
        vecs.push_back('{DIV_OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  LAT_FULL});
        vecs.push_back('{DIV_OP_REMU, 32'hFFFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF,  LAT_FULL});
        vecs.push_back('{DIV_OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  LAT_FULL});
        vecs.push_back('{DIV_OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          LAT_FULL});
        vecs.push_back('{DIV_OP_DIV,  32'd1000,       32'd7,          32'd142,        LAT_FULL});
        vecs.push_back('{DIV_OP_REM,  32'd1000,       32'd7,          32'd6,          LAT_HIT});
        vecs.push_back('{DIV_OP_REMU, 32'd1000,       32'd7,          32'd6,          LAT_FULL});

        foreach (vecs[i]) begin
            run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // Flush in CALC cycle 10 of DIVU 1000/3
        @(negedge clk);
        start = 1'b1; op = DIV_OP_DIVU; dividend = 32'd1000; divisor = 32'd3;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush stall", 32'(stall_req), 32'd0);
        chk("flush valid", 32'(result_valid), 32'd0);
        chk("flush busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0; start = 1'b0;
        chk("flush idle", 32'(busy), 32'd0);
        rv_seen = 0;
        repeat (LAT_FULL + 5) begin
            @(negedge clk);
            if (result_valid) rv_seen++;
        end
        chk("flush no result", 32'(rv_seen), 32'd0);
        run_op("after flush", DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, LAT_FULL);

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        start = 1'b1; op = DIV_OP_DIV; dividend = 32'd100; divisor = 32'd3;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst stall", 32'(stall_req), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst valid", 32'(result_valid), 32'd0);
        chk("rst result", result, 32'd0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rv_seen = 0;
        repeat (LAT_FULL + 5) begin
            @(negedge clk);
            if (result_valid) rv_seen++;
        end
        chk("rst no result", 32'(rv_seen), 32'd0);
        run_op("after rst", DIV_OP_DIV, 32'd20, 32'd4, 32'd5, LAT_FULL);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
